// File: rtl/core_dbg_pkg.sv
// rtl/core_dbg_pkg.sv - debug register map, command/status bit positions and run-control state type
package core_dbg_pkg;

   // Architected register addresses; everything from REG_SCRATCH0 up is scratch
   localparam int unsigned REG_CTRL     = 0;
   localparam int unsigned REG_STATUS   = 1;
   localparam int unsigned REG_PC       = 2;
   localparam int unsigned REG_ID       = 3;
   localparam int unsigned REG_SCRATCH0 = 4;

   // CTRL command bits (self-clearing pulses)
   localparam int unsigned CTRL_HALT    = 0;
   localparam int unsigned CTRL_RESUME  = 1;
   localparam int unsigned CTRL_STEP    = 2;
   localparam int unsigned CTRL_CLR_ERR = 3;

   // STATUS fields
   localparam int unsigned STAT_HALTED    = 0;
   localparam int unsigned STAT_RUNNING   = 1;
   localparam int unsigned STAT_STEPPING  = 2;
   localparam int unsigned STAT_ERR       = 3;
   localparam int unsigned STAT_STATE_LSB = 4;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_WAIT = 2'd1,
      HALTED    = 2'd2,
      STEP      = 2'd3
   } dbg_state_t;

endpackage

// File: rtl/core_dbg_if.sv
// rtl/core_dbg_if.sv - request/response bus between the APB debug bridge and the core debug unit
interface core_dbg_if #(
   parameter int unsigned DBG_ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH     = 32
);
   logic                      dbg_req;
   logic                      dbg_wr_rd;
   logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0]     dbg_wdata;
   logic [DATA_WIDTH-1:0]     dbg_rdata;
   logic                      dbg_rd_ready;

   modport master (
      output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_rd_ready
   );

   modport slave (
      input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_rd_ready
   );
endinterface

// File: rtl/core_dbg_runctl.sv
// rtl/core_dbg_runctl.sv - halt/resume/single-step run-control state machine
module core_dbg_runctl
   import core_dbg_pkg::*;
#(
   parameter bit RST_HALTED = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       halt_i,
   input  logic       resume_i,
   input  logic       step_i,
   input  logic       core_idle_i,
   output dbg_state_t state_o,
   output logic       fetch_en_o,
   output logic       halted_o
);

   dbg_state_t state_q, state_d;
   logic       fetch_en_q, halted_q;
   logic       resume_sel, step_sel;

   // Several command bits in one write resolve to a single command: HALT > RESUME > STEP
   assign resume_sel = resume_i && !halt_i;
   assign step_sel   = step_i && !halt_i && !resume_i;

   // Next state; commands not meaningful in the current state are dropped
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:       if (halt_i) state_d = HALT_WAIT;
         HALT_WAIT: if (resume_sel) state_d = RUN;
                    else if (core_idle_i) state_d = HALTED;
         HALTED:    if (resume_sel) state_d = RUN;
                    else if (step_sel) state_d = STEP;
         STEP:      state_d = HALT_WAIT;
      endcase
   end

   // State register with outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_HALTED ? HALTED : RUN;
         fetch_en_q <= !RST_HALTED;
         halted_q   <= RST_HALTED;
      end else begin
         state_q    <= state_d;
         fetch_en_q <= (state_d == RUN) || (state_d == STEP);
         halted_q   <= (state_d == HALTED);
      end
   end

   assign state_o    = state_q;
   assign fetch_en_o = fetch_en_q;
   assign halted_o   = halted_q;

endmodule

// File: rtl/core_dbg_unit.sv
// rtl/core_dbg_unit.sv - core-side debug unit: register decode, scratch file, sticky error, PC override
module core_dbg_unit
   import core_dbg_pkg::*;
#(
   parameter int unsigned DBG_ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_REGS       = 32,
   parameter int unsigned PC_WIDTH       = 30,
   parameter logic [31:0] CORE_ID        = 32'h5441_4301,
   parameter bit          RST_HALTED     = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   core_dbg_if.slave           dbg,
   input  logic [PC_WIDTH-1:0] core_pc_i,
   input  logic                core_idle_i,
   output logic                fetch_en_o,
   output logic                pc_load_o,
   output logic [PC_WIDTH-1:0] pc_load_addr_o,
   output logic                halted_o
);

   localparam logic [DBG_ADDR_WIDTH:0] NUM_REGS_W = (DBG_ADDR_WIDTH + 1)'(NUM_REGS);
   localparam int unsigned             IDX_W      = $clog2(NUM_REGS);

   // Entries below REG_SCRATCH0 are never written; only the scratch range is live
   logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] status_word;
   logic                  rd_ready_q;
   logic                  pc_load_q;
   logic [PC_WIDTH-1:0]   pc_load_addr_q;
   logic                  err_q, err_d;

   dbg_state_t            state;
   logic                  wr_acc, rd_acc, in_range;
   logic                  is_ctrl, is_status, is_pc, is_id, is_scr;
   logic                  halt_cmd, resume_cmd, step_cmd, clr_cmd;
   logic                  pc_wr_ok, err_set;
   logic [IDX_W-1:0]      scr_idx;

   assign wr_acc    = dbg.dbg_req && dbg.dbg_wr_rd;
   assign rd_acc    = dbg.dbg_req && !dbg.dbg_wr_rd;
   assign in_range  = {1'b0, dbg.dbg_addr} < NUM_REGS_W;
   assign is_ctrl   = dbg.dbg_addr == DBG_ADDR_WIDTH'(REG_CTRL);
   assign is_status = dbg.dbg_addr == DBG_ADDR_WIDTH'(REG_STATUS);
   assign is_pc     = dbg.dbg_addr == DBG_ADDR_WIDTH'(REG_PC);
   assign is_id     = dbg.dbg_addr == DBG_ADDR_WIDTH'(REG_ID);
   assign is_scr    = in_range && (dbg.dbg_addr >= DBG_ADDR_WIDTH'(REG_SCRATCH0));
   assign scr_idx   = dbg.dbg_addr[IDX_W-1:0];

   assign halt_cmd   = wr_acc && is_ctrl && dbg.dbg_wdata[CTRL_HALT];
   assign resume_cmd = wr_acc && is_ctrl && dbg.dbg_wdata[CTRL_RESUME];
   assign step_cmd   = wr_acc && is_ctrl && dbg.dbg_wdata[CTRL_STEP];
   assign clr_cmd    = wr_acc && is_ctrl && dbg.dbg_wdata[CTRL_CLR_ERR];

   // The PC can only be overridden while the core is parked
   assign pc_wr_ok = wr_acc && is_pc && (state == HALTED);
   assign err_set  = (wr_acc && ((is_pc && (state != HALTED)) || is_id || !in_range))
                   || (rd_acc && !in_range);

   core_dbg_runctl #(
      .RST_HALTED (RST_HALTED)
   ) u_runctl (
      .clk         (clk),
      .rst         (rst),
      .halt_i      (halt_cmd),
      .resume_i    (resume_cmd),
      .step_i      (step_cmd),
      .core_idle_i (core_idle_i),
      .state_o     (state),
      .fetch_en_o  (fetch_en_o),
      .halted_o    (halted_o)
   );

   // STATUS image of the current run-control state and sticky error
   always_comb begin
      status_word                          = '0;
      status_word[STAT_HALTED]             = (state == HALTED);
      status_word[STAT_RUNNING]            = (state == RUN);
      status_word[STAT_STEPPING]           = (state == STEP);
      status_word[STAT_ERR]                = err_q;
      status_word[STAT_STATE_LSB +: 4]     = {2'b00, state};
   end

   // Read mux; CTRL and unimplemented addresses read as zero
   always_comb begin
      rdata_d = '0;
      if (is_status)      rdata_d = status_word;
      else if (is_pc)     rdata_d = DATA_WIDTH'(core_pc_i);
      else if (is_id)     rdata_d = DATA_WIDTH'(CORE_ID);
      else if (is_scr)    rdata_d = scratch_q[scr_idx];
   end

   // Sticky error: cleared by CLR_ERR, set by any illegal access
   always_comb begin
      err_d = err_q;
      if (clr_cmd) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   // Register file, read response, error flag and PC override strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) scratch_q[i] <= '0;
         rdata_q        <= '0;
         rd_ready_q     <= 1'b0;
         pc_load_q      <= 1'b0;
         pc_load_addr_q <= '0;
         err_q          <= 1'b0;
      end else begin
         rd_ready_q <= rd_acc;
         if (rd_acc) rdata_q <= rdata_d;
         pc_load_q <= pc_wr_ok;
         if (pc_wr_ok) pc_load_addr_q <= dbg.dbg_wdata[PC_WIDTH-1:0];
         if (wr_acc && is_scr) scratch_q[scr_idx] <= dbg.dbg_wdata;
         err_q <= err_d;
      end
   end

   assign dbg.dbg_rdata    = rdata_q;
   assign dbg.dbg_rd_ready = rd_ready_q;
   assign pc_load_o        = pc_load_q;
   assign pc_load_addr_o   = pc_load_addr_q;

endmodule

// File: tb/tb_core_dbg_unit.sv
// tb/tb_core_dbg_unit.sv - self-checking bench for core_dbg_unit against a behavioural model
module tb_core_dbg_unit;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 16;
   localparam int PCW  = 30;
   localparam logic [31:0] ID_VAL = 32'h5441_4301;

   // Architected state codes as seen in STATUS[7:4]
   localparam int S_RUN = 0, S_HW = 1, S_HALTED = 2, S_STEP = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [PCW-1:0] core_pc = '0;
   logic           core_idle = 1'b0;
   logic           fetch_en, pc_load, halted;
   logic [PCW-1:0] pc_load_addr;

   core_dbg_if #(.DBG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg_bus ();

   core_dbg_unit #(
      .DBG_ADDR_WIDTH (AW),
      .DATA_WIDTH     (DW),
      .NUM_REGS       (NREG),
      .PC_WIDTH       (PCW),
      .CORE_ID        (ID_VAL),
      .RST_HALTED     (1'b0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dbg            (dbg_bus),
      .core_pc_i      (core_pc),
      .core_idle_i    (core_idle),
      .fetch_en_o     (fetch_en),
      .pc_load_o      (pc_load),
      .pc_load_addr_o (pc_load_addr),
      .halted_o       (halted)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   int             m_state;
   bit             m_err;
   logic [31:0]    m_scr [NREG];
   logic [31:0]    m_rdata;
   bit             m_rd_ready;
   bit             m_pc_load;
   logic [PCW-1:0] m_pc_addr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] status_val();
      logic [31:0] v;
      v = 32'(m_state) << 4;
      if (m_err)              v = v | 32'h8;
      if (m_state == S_STEP)  v = v | 32'h4;
      if (m_state == S_RUN)   v = v | 32'h2;
      if (m_state == S_HALTED) v = v | 32'h1;
      return v;
   endfunction

   task automatic model_reset();
      m_state    = S_RUN;
      m_err      = 1'b0;
      m_rdata    = '0;
      m_rd_ready = 1'b0;
      m_pc_load  = 1'b0;
      m_pc_addr  = '0;
      for (int i = 0; i < NREG; i++) m_scr[i] = '0;
   endtask

   // Advance the model by one clock edge using the inputs presented at that edge
   task automatic model_edge();
      int          a;
      int          cmd;
      logic [31:0] wd;
      logic [31:0] rv;
      if (rst) begin
         model_reset();
         return;
      end
      a          = int'(dbg_bus.dbg_addr);
      wd         = dbg_bus.dbg_wdata;
      cmd        = 0;
      m_rd_ready = 1'b0;
      m_pc_load  = 1'b0;
      if (dbg_bus.dbg_req && !dbg_bus.dbg_wr_rd) begin
         m_rd_ready = 1'b1;
         rv = '0;
         if (a == 1)                  rv = status_val();
         else if (a == 2)             rv = 32'(core_pc);
         else if (a == 3)             rv = ID_VAL;
         else if (a >= 4 && a < NREG) rv = m_scr[a];
         else if (a >= NREG)          m_err = 1'b1;
         m_rdata = rv;
      end else if (dbg_bus.dbg_req) begin
         if (a == 0) begin
            if (wd[0])      cmd = 1;
            else if (wd[1]) cmd = 2;
            else if (wd[2]) cmd = 3;
            if (wd[3]) m_err = 1'b0;
         end else if (a == 2) begin
            if (m_state == S_HALTED) begin
               m_pc_load = 1'b1;
               m_pc_addr = wd[PCW-1:0];
            end else begin
               m_err = 1'b1;
            end
         end else if (a == 3 || a >= NREG) begin
            m_err = 1'b1;
         end else if (a >= 4) begin
            m_scr[a] = wd;
         end
      end
      // cmd: 1 halt, 2 resume, 3 step
      if (m_state == S_RUN) begin
         if (cmd == 1) m_state = S_HW;
      end else if (m_state == S_HW) begin
         if (cmd == 2) m_state = S_RUN;
         else if (core_idle) m_state = S_HALTED;
      end else if (m_state == S_HALTED) begin
         if (cmd == 2) m_state = S_RUN;
         else if (cmd == 3) m_state = S_STEP;
      end else begin
         m_state = S_HW;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("rd_ready", 32'(dbg_bus.dbg_rd_ready), 32'(m_rd_ready));
      chk("rdata", dbg_bus.dbg_rdata, m_rdata);
      chk("fetch_en", 32'(fetch_en), 32'((m_state == S_RUN) || (m_state == S_STEP)));
      chk("halted", 32'(halted), 32'(m_state == S_HALTED));
      chk("pc_load", 32'(pc_load), 32'(m_pc_load));
      chk("pc_load_addr", 32'(pc_load_addr), 32'(m_pc_addr));
   endtask

   task automatic bus_idle();
      dbg_bus.dbg_req = 1'b0;
      tick();
   endtask

   task automatic bus_wr(input int a, input logic [31:0] d);
      dbg_bus.dbg_req   = 1'b1;
      dbg_bus.dbg_wr_rd = 1'b1;
      dbg_bus.dbg_addr  = AW'(a);
      dbg_bus.dbg_wdata = d;
      tick();
      dbg_bus.dbg_req   = 1'b0;
   endtask

   task automatic bus_rd(input int a);
      dbg_bus.dbg_req   = 1'b1;
      dbg_bus.dbg_wr_rd = 1'b0;
      dbg_bus.dbg_addr  = AW'(a);
      dbg_bus.dbg_wdata = $urandom;
      tick();
      dbg_bus.dbg_req   = 1'b0;
   endtask

   initial begin
      int          pick;
      logic [31:0] cmd_w;
      dbg_bus.dbg_req   = 1'b0;
      dbg_bus.dbg_wr_rd = 1'b0;
      dbg_bus.dbg_addr  = '0;
      dbg_bus.dbg_wdata = '0;
      model_reset();
      core_pc = 30'h0000_1234;

      // Reset and identity
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_fetch_en", 32'(fetch_en), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_rdata", dbg_bus.dbg_rdata, 32'd0);
      bus_rd(1);
      chk("status_run", dbg_bus.dbg_rdata, 32'h02);
      chk("status_rdy", 32'(dbg_bus.dbg_rd_ready), 32'd1);
      bus_idle();
      chk("rdy_pulse", 32'(dbg_bus.dbg_rd_ready), 32'd0);
      bus_rd(3);
      chk("id", dbg_bus.dbg_rdata, ID_VAL);

      // Scratch write/read and back-to-back reads
      bus_wr(4, 32'hA5A5_0001);
      chk("wr_no_rdy", 32'(dbg_bus.dbg_rd_ready), 32'd0);
      bus_rd(4);
      chk("scr4", dbg_bus.dbg_rdata, 32'hA5A5_0001);
      bus_rd(4);
      chk("b2b_scr4", dbg_bus.dbg_rdata, 32'hA5A5_0001);
      bus_rd(3);
      chk("b2b_id", dbg_bus.dbg_rdata, ID_VAL);
      chk("b2b_rdy", 32'(dbg_bus.dbg_rd_ready), 32'd1);

      // Halt with a busy core, then let it drain
      core_idle = 1'b0;
      bus_wr(0, 32'h1);
      chk("hw_fetch", 32'(fetch_en), 32'd0);
      bus_idle();
      bus_idle();
      bus_idle();
      chk("hw_not_halted", 32'(halted), 32'd0);
      bus_rd(1);
      chk("status_hw", dbg_bus.dbg_rdata, 32'h10);
      core_idle = 1'b1;
      bus_idle();
      chk("halted_now", 32'(halted), 32'd1);
      bus_rd(1);
      chk("status_halted", dbg_bus.dbg_rdata, 32'h21);

      // PC override and single step
      bus_wr(2, 32'h0000_0100);
      chk("pc_load", 32'(pc_load), 32'd1);
      chk("pc_load_addr", 32'(pc_load_addr), 32'h100);
      bus_idle();
      chk("pc_load_pulse", 32'(pc_load), 32'd0);
      core_idle = 1'b0;
      bus_wr(0, 32'h4);
      chk("step_fetch", 32'(fetch_en), 32'd1);
      bus_idle();
      chk("step_one_cycle", 32'(fetch_en), 32'd0);
      core_idle = 1'b1;
      bus_idle();
      chk("step_rehalt", 32'(halted), 32'd1);

      // Illegal accesses and error clear
      bus_wr(0, 32'h2);
      bus_idle();
      bus_wr(2, 32'h0000_0055);
      chk("pc_wr_run", 32'(pc_load), 32'd0);
      bus_rd(1);
      chk("status_err", dbg_bus.dbg_rdata, 32'h0A);
      bus_rd(31);
      chk("oob_read", dbg_bus.dbg_rdata, 32'd0);
      bus_wr(0, 32'h8);
      bus_rd(1);
      chk("err_clr", dbg_bus.dbg_rdata, 32'h02);

      // Halt beats resume; reset aborts an in-flight write
      core_idle = 1'b0;
      bus_wr(0, 32'h3);
      chk("halt_wins", 32'(fetch_en), 32'd0);
      bus_rd(1);
      chk("status_hw2", dbg_bus.dbg_rdata, 32'h10);
      rst = 1'b1;
      bus_wr(5, 32'hDEAD_BEEF);
      tick();
      rst = 1'b0;
      bus_idle();
      chk("rst_run", 32'(fetch_en), 32'd1);
      bus_rd(4);
      chk("rst_scr4", dbg_bus.dbg_rdata, 32'd0);
      bus_rd(5);
      chk("rst_scr5", dbg_bus.dbg_rdata, 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 800; n++) begin
         core_idle = ($urandom_range(0, 2) != 0);
         core_pc   = PCW'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            bus_idle();
            rst = 1'b0;
         end else begin
            pick = $urandom_range(0, 11);
            case (pick)
               0:       bus_idle();
               1, 2, 3: bus_rd($urandom_range(0, 31));
               4, 5:    bus_wr($urandom_range(4, NREG - 1), $urandom);
               6:       bus_wr($urandom_range(NREG, 31), $urandom);
               7:       bus_wr(2, $urandom);
               8:       bus_wr(3, $urandom);
               default: begin
                  cmd_w = 32'h1 << $urandom_range(0, 3);
                  bus_wr(0, cmd_w);
               end
            endcase
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
